// File: rtl/div_seq_unit.sv
// Sequential restoring divider for DIV/DIVU: one quotient bit per clock, with its own control FSM.
// Signs are stripped on entry and reapplied in FIX; divide-by-zero bypasses CALC entirely.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | waiting for St; Done is high for the first cycle after FIX
//   CALC  | one shift-subtract step per edge, count runs WIDTH-1 down to 0
//   FIX   | apply signs (or the divide-by-zero result), pulse Done
module div_seq_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             St,
  input  logic             Signed,
  input  logic [WIDTH-1:0] Dividend,
  input  logic [WIDTH-1:0] Divisor,
  output logic [WIDTH-1:0] Quo,
  output logic [WIDTH-1:0] Rem,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b;
  logic             sd, sv, dz;
  logic             accept;
  logic             divisor_zero;
  logic [WIDTH-1:0] dividend_mag, divisor_mag;
  logic [WIDTH+1:0] r_sh, r_diff;
  logic             r_ge;

  assign divisor_zero = (Divisor == '0);
  assign dividend_mag = (Signed && Dividend[WIDTH-1]) ? -Dividend : Dividend;
  assign divisor_mag  = (Signed && Divisor[WIDTH-1])  ? -Divisor  : Divisor;

  // r_sh < 2^(WIDTH+1) and b < 2^WIDTH, so the top bit of r_diff is a clean borrow flag.
  assign r_sh   = {r, q[WIDTH-1]};
  assign r_diff = r_sh - {2'b00, b};
  assign r_ge   = ~r_diff[WIDTH+1];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (St) begin
          accept    = 1'b1;
          state_nxt = divisor_zero ? FIX : CALC;
        end
      end
      CALC:    if (count == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count   <= '0;
      r       <= '0;
      q       <= '0;
      b       <= '0;
      sd      <= 1'b0;
      sv      <= 1'b0;
      dz      <= 1'b0;
      Quo     <= '0;
      Rem     <= '0;
      Busy    <= 1'b0;
      Done    <= 1'b0;
      DivZero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          Done <= 1'b0;
          if (accept) begin
            sd      <= Signed & Dividend[WIDTH-1];
            sv      <= Signed & Divisor[WIDTH-1];
            b       <= divisor_mag;
            // On divide-by-zero q carries the raw dividend straight through to Rem.
            q       <= divisor_zero ? Dividend : dividend_mag;
            r       <= '0;
            dz      <= divisor_zero;
            count   <= CW'(WIDTH - 1);
            Busy    <= 1'b1;
            DivZero <= 1'b0;
          end
        end
        CALC: begin
          r     <= r_ge ? r_diff[WIDTH:0] : r_sh[WIDTH:0];
          q     <= {q[WIDTH-2:0], r_ge};
          count <= count - 1'b1;
        end
        FIX: begin
          if (dz) begin
            Quo     <= '1;
            Rem     <= q;
            DivZero <= 1'b1;
          end else begin
            Quo <= (sd ^ sv) ? -q : q;
            Rem <= sd ? -r[WIDTH-1:0] : r[WIDTH-1:0];
          end
          Done <= 1'b1;
          Busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_unit.sv
// Self-checking bench for div_seq_unit: directed cases plus randomized operations compared
// against a plain-arithmetic reference model.
module tb_div_seq_unit;

  localparam int WIDTH = 32;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        St = 1'b0;
  logic        Signed = 1'b0;
  logic [31:0] Dividend = '0;
  logic [31:0] Divisor = '0;
  logic [31:0] Quo, Rem;
  logic        Busy, Done, DivZero;

  int nvec = 0;
  int nerr = 0;

  div_seq_unit #(.WIDTH(WIDTH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .St(St), .Signed(Signed),
    .Dividend(Dividend), .Divisor(Divisor), .Quo(Quo), .Rem(Rem),
    .Busy(Busy), .Done(Done), .DivZero(DivZero)
  );

  always #5 Clk = ~Clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // DIV/DIVU semantics: truncating division, remainder takes the dividend's sign.
  function automatic void ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] d,
                                  output logic [31:0] q, output logic [31:0] r, output logic z);
    longint sa, sd;
    if (d == 0) begin
      q = '1; r = a; z = 1'b1;
    end else if (sgn) begin
      sa = $signed(a);
      sd = $signed(d);
      q = 32'(sa / sd); r = 32'(sa % sd); z = 1'b0;
    end else begin
      q = a / d; r = a % d; z = 1'b0;
    end
  endfunction

  // Start one operation; lat = edge index (accept edge = 0) after which Done was seen, -1 on timeout.
  task automatic run_op(input logic sgn, input logic [31:0] a, input logic [31:0] d,
                        output logic [31:0] q, output logic [31:0] r, output logic z,
                        output int lat, output logic busy0);
    int e;
    @(negedge Clk);
    Signed = sgn; Dividend = a; Divisor = d; St = 1'b1;
    @(posedge Clk);
    e = 0; lat = -1; busy0 = 1'b0; q = '0; r = '0; z = 1'b0;
    while (1) begin
      @(negedge Clk);
      if (e == 0) begin
        busy0 = Busy;
        St = 1'b0; Signed = 1'($urandom); Dividend = $urandom; Divisor = $urandom;
      end
      if (Done) begin
        lat = e; q = Quo; r = Rem; z = DivZero;
        break;
      end
      if (e >= 60) break;
      @(posedge Clk);
      e++;
    end
  endtask

  task automatic test_reset();
    #3;
    nvec++;
    if ({Quo, Rem, Busy, Done, DivZero} !== '0) begin
      nerr++; $display("FAIL reset_state: got quo=%h rem=%h busy=%b done=%b dz=%b, want all 0",
                       Quo, Rem, Busy, Done, DivZero);
    end
    @(negedge Clk); Reset_n = 1'b1;
  endtask

  task automatic test_unsigned();
    logic [31:0] q, r; logic z, b0; int lat;
    run_op(1'b0, 32'd100, 32'd7, q, r, z, lat, b0);
    nvec++; if (b0 !== 1'b1) begin nerr++; $display("FAIL unsigned_busy: got %b want 1", b0); end
    nvec++; if (lat != 33)   begin nerr++; $display("FAIL unsigned_latency: got %0d want 33", lat); end
    nvec++; if (q !== 32'd14) begin nerr++; $display("FAIL unsigned_quo: got %h want %h", q, 32'd14); end
    nvec++; if (r !== 32'd2)  begin nerr++; $display("FAIL unsigned_rem: got %h want %h", r, 32'd2); end
    nvec++; if (z !== 1'b0)   begin nerr++; $display("FAIL unsigned_dz: got %b want 0", z); end
  endtask

  task automatic test_signed();
    logic [31:0] q, r; logic z, b0; int lat;
    run_op(1'b1, 32'hFFFF_FFF9, 32'd2, q, r, z, lat, b0);
    nvec++; if (q !== 32'hFFFF_FFFD) begin nerr++; $display("FAIL signed_quo: got %h want fffffffd", q); end
    nvec++; if (r !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL signed_rem: got %h want ffffffff", r); end
  endtask

  task automatic test_overflow();
    logic [31:0] q, r; logic z, b0; int lat;
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, q, r, z, lat, b0);
    nvec++; if (q !== 32'h8000_0000) begin nerr++; $display("FAIL ovf_signed_quo: got %h want 80000000", q); end
    nvec++; if (r !== 32'h0)         begin nerr++; $display("FAIL ovf_signed_rem: got %h want 0", r); end
    run_op(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, q, r, z, lat, b0);
    nvec++; if (q !== 32'h0)         begin nerr++; $display("FAIL ovf_unsigned_quo: got %h want 0", q); end
    nvec++; if (r !== 32'h8000_0000) begin nerr++; $display("FAIL ovf_unsigned_rem: got %h want 80000000", r); end
  endtask

  task automatic test_divzero();
    logic [31:0] q, r; logic z, b0; int lat;
    run_op(1'b1, 32'h1234, 32'h0, q, r, z, lat, b0);
    nvec++; if (lat != 1)            begin nerr++; $display("FAIL dz_latency: got %0d want 1", lat); end
    nvec++; if (q !== 32'hFFFF_FFFF) begin nerr++; $display("FAIL dz_quo: got %h want ffffffff", q); end
    nvec++; if (r !== 32'h1234)      begin nerr++; $display("FAIL dz_rem: got %h want 1234", r); end
    nvec++; if (z !== 1'b1)          begin nerr++; $display("FAIL dz_flag: got %b want 1", z); end
  endtask

  task automatic test_abort();
    logic [31:0] q, r; logic z, b0; int lat, ndone;
    @(negedge Clk);
    Signed = 1'b0; Dividend = 32'd5000; Divisor = 32'd9; St = 1'b1;
    @(posedge Clk);
    @(negedge Clk); St = 1'b0;
    repeat (9) @(posedge Clk);
    @(negedge Clk);
    Reset_n = 1'b0;
    #1;
    nvec++;
    if ({Quo, Rem, Busy, Done, DivZero} !== '0) begin
      nerr++; $display("FAIL abort_clear: got quo=%h rem=%h busy=%b done=%b dz=%b, want all 0",
                       Quo, Rem, Busy, Done, DivZero);
    end
    @(negedge Clk); Reset_n = 1'b1;
    ndone = 0;
    repeat (50) begin
      @(negedge Clk);
      if (Done) ndone++;
    end
    nvec++; if (ndone != 0) begin nerr++; $display("FAIL abort_no_done: got %0d pulses want 0", ndone); end
    run_op(1'b0, 32'd5000, 32'd9, q, r, z, lat, b0);
    nvec++; if (lat != 33 || q !== 32'd555 || r !== 32'd5) begin
      nerr++; $display("FAIL abort_recover: got lat=%0d quo=%h rem=%h want lat=33 quo=%h rem=%h",
                       lat, q, r, 32'd555, 32'd5);
    end
  endtask

  task automatic test_busy_ignore();
    logic [31:0] q, r; int ndone; logic busy5;
    @(negedge Clk);
    Signed = 1'b0; Dividend = 32'd1000; Divisor = 32'd3; St = 1'b1;
    @(posedge Clk);
    ndone = 0; busy5 = 1'b0; q = '0; r = '0;
    for (int e = 0; e <= 80; e++) begin
      @(negedge Clk);
      if (e == 0) St = 1'b0;
      if (e == 5) begin busy5 = Busy; St = 1'b1; Dividend = 32'd77; Divisor = 32'd5; end
      if (e == 6) St = 1'b0;
      if (Done) begin ndone++; q = Quo; r = Rem; end
      @(posedge Clk);
    end
    nvec++; if (busy5 !== 1'b1) begin nerr++; $display("FAIL ignore_busy: got %b want 1", busy5); end
    nvec++; if (ndone != 1)     begin nerr++; $display("FAIL ignore_done_count: got %0d want 1", ndone); end
    nvec++; if (q !== 32'd333 || r !== 32'd1) begin
      nerr++; $display("FAIL ignore_result: got quo=%h rem=%h want quo=%h rem=%h", q, r, 32'd333, 32'd1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] q1, r1, q2, r2; int d1, d2;
    @(negedge Clk);
    Signed = 1'b0; Dividend = 32'd1000; Divisor = 32'd7; St = 1'b1;
    @(posedge Clk);
    d1 = -1; d2 = -1; q1 = '0; r1 = '0; q2 = '0; r2 = '0;
    for (int e = 0; e <= 100; e++) begin
      @(negedge Clk);
      if (e == 1) begin Signed = 1'b1; Dividend = 32'hFFFF_FF9C; Divisor = 32'd7; end
      if (e == 34) St = 1'b0;
      if (Done) begin
        if (d1 < 0) begin d1 = e; q1 = Quo; r1 = Rem; end
        else if (d2 < 0) begin d2 = e; q2 = Quo; r2 = Rem; end
      end
      @(posedge Clk);
    end
    nvec++; if (d1 != 33 || d2 != 67) begin
      nerr++; $display("FAIL b2b_timing: got done at %0d,%0d want 33,67", d1, d2);
    end
    nvec++; if (q1 !== 32'd142 || r1 !== 32'd6) begin
      nerr++; $display("FAIL b2b_first: got quo=%h rem=%h want quo=%h rem=%h", q1, r1, 32'd142, 32'd6);
    end
    nvec++; if (q2 !== 32'hFFFF_FFF2 || r2 !== 32'hFFFF_FFFE) begin
      nerr++; $display("FAIL b2b_second: got quo=%h rem=%h want quo=fffffff2 rem=fffffffe", q2, r2);
    end
  endtask

  task automatic test_random();
    logic [31:0] a, d, q, r, eq, er; logic sgn, z, ez, b0; int lat, mode;
    for (int i = 0; i < 24; i++) begin
      sgn  = 1'($urandom);
      a    = ($urandom_range(0, 7) == 0) ? 32'h8000_0000 : $urandom;
      mode = $urandom_range(0, 7);
      if (mode == 0)      d = 32'h0;
      else if (mode < 4)  d = $urandom_range(1, 15);
      else if (mode == 4) d = 32'hFFFF_FFFF;
      else                d = $urandom >> $urandom_range(0, 28);
      ref_div(sgn, a, d, eq, er, ez);
      run_op(sgn, a, d, q, r, z, lat, b0);
      nvec++; if (lat != (ez ? 1 : 33)) begin
        nerr++; $display("FAIL rand%0d_latency: got %0d want %0d", i, lat, ez ? 1 : 33);
      end
      nvec++; if (q !== eq) begin
        nerr++; $display("FAIL rand%0d_quo: s=%b %h/%h got %h want %h", i, sgn, a, d, q, eq);
      end
      nvec++; if (r !== er) begin
        nerr++; $display("FAIL rand%0d_rem: s=%b %h/%h got %h want %h", i, sgn, a, d, r, er);
      end
      nvec++; if (z !== ez) begin
        nerr++; $display("FAIL rand%0d_dz: got %b want %b", i, z, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_overflow();
    test_divzero();
    test_abort();
    test_busy_ignore();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
